// File: rtl/cpu_mem_responder.sv
// cpu_mem_responder
// Memory-side responder for the multi-cycle RISC-V core. It serves the
// read-only instruction port and the read/write load/store port from one
// word-organised, byte-enabled RAM. Both ports have a fixed 1-cycle
// registered read latency.
//
// The core presents and consumes right-aligned sub-word data. This block
// shifts store data up into the addressed byte lane, and shifts load data
// back down to bit 0 with zero extension. The core does any sign extension.
//
// Optional feature, enabled by defining the macro RESP_MMIO_EN:
//   0xFFFF_FFF0  32-bit output register, driven out on o_mmio_out
//   0xFFFF_FFF4  read-only free-running cycle counter
// When the macro is undefined there is no MMIO decode. Those addresses
// alias into RAM like any other address.
//
// Ports:
//   clk             rising-edge clock
//   reset_n         asynchronous active-low reset (RAM contents are kept)
//   i_pc_addr       instruction byte address
//   i_pc_rd         instruction read request (single-cycle pulse)
//   i_pc_byte_en    instruction byte enables; only 4'b1111 is legal
//   o_pc_rddata     fetched instruction word
//   o_pc_valid      o_pc_rddata was updated this cycle
//   i_ldst_addr     load/store byte address
//   i_ldst_rd       load request
//   i_ldst_wr       store request
//   i_ldst_wrdata   right-aligned store data
//   i_ldst_byte_en  4'b0001 byte, 4'b0011 half, 4'b1111 word
//   o_ldst_rddata   right-aligned, zero-extended load data
//   o_ldst_valid    o_ldst_rddata was updated this cycle
//   o_err           sticky misalignment/illegal-request flag
//   o_mmio_out      MMIO output register (only with RESP_MMIO_EN)
module cpu_mem_responder #(
  parameter int IW          = 32,
  parameter int DEPTH_WORDS = 4096,
  localparam int AW         = $clog2(DEPTH_WORDS)
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic [IW-1:0] i_pc_addr,
  input  logic          i_pc_rd,
  input  logic [3:0]    i_pc_byte_en,
  output logic [IW-1:0] o_pc_rddata,
  output logic          o_pc_valid,
  input  logic [IW-1:0] i_ldst_addr,
  input  logic          i_ldst_rd,
  input  logic          i_ldst_wr,
  input  logic [IW-1:0] i_ldst_wrdata,
  input  logic [3:0]    i_ldst_byte_en,
  output logic [IW-1:0] o_ldst_rddata,
  output logic          o_ldst_valid,
  output logic          o_err
`ifdef RESP_MMIO_EN
  ,
  output logic [IW-1:0] o_mmio_out
`endif
);

  logic [IW-1:0] mem [DEPTH_WORDS];

  logic [AW-1:0] pc_idx;
  logic          pc_bad;

  logic [AW-1:0] ls_idx;
  logic [1:0]    ls_lane;
  logic [4:0]    lane_shift;
  logic          is_byte;
  logic          is_half;
  logic          is_word;
  logic          ls_illegal;
  logic          ls_bad;
  logic          ram_we;
  logic [3:0]    wr_mask;
  logic [IW-1:0] wr_data;
  logic [IW-1:0] src_word;
  logic [IW-1:0] shifted;
  logic [IW-1:0] ld_data;

  logic          mmio_hit;
  logic          mmio_store_bad;
  logic [IW-1:0] mmio_word;

  // Upper address bits are ignored, so accesses alias modulo the RAM size.
  logic unused_pc_bits;
  assign unused_pc_bits = ^i_pc_addr[IW-1:AW+2];

  // A misaligned fetch still returns the word at the aligned address.
  // That happens naturally here, because the index ignores bits [1:0].
  assign pc_idx = i_pc_addr[AW+1:2];
  assign pc_bad = i_pc_rd && ((i_pc_byte_en != 4'b1111) || (i_pc_addr[1:0] != 2'b00));

  assign ls_idx     = i_ldst_addr[AW+1:2];
  assign ls_lane    = i_ldst_addr[1:0];
  assign lane_shift = {ls_lane, 3'b000};

  assign is_byte = (i_ldst_byte_en == 4'b0001);
  assign is_half = (i_ldst_byte_en == 4'b0011);
  assign is_word = (i_ldst_byte_en == 4'b1111);

  // An illegal access writes nothing and loads zero, but still returns valid.
  assign ls_illegal = (i_ldst_rd && i_ldst_wr)
                    || !(is_byte || is_half || is_word)
                    || (is_half && ls_lane[0])
                    || (is_word && (ls_lane != 2'b00));

  assign ls_bad = ((i_ldst_rd || i_ldst_wr) && ls_illegal) || mmio_store_bad;

  assign ram_we  = i_ldst_wr && !ls_illegal && !mmio_hit;
  assign wr_mask = i_ldst_byte_en << ls_lane;
  assign wr_data = i_ldst_wrdata << lane_shift;

`ifdef RESP_MMIO_EN
  logic [IW-1:0] mmio_reg;
  logic [IW-1:0] cycle_cnt;
  logic          sel_out;
  logic          sel_cnt;
  logic          mmio_reg_we;

  assign mmio_hit  = &i_ldst_addr[IW-1:4];
  assign sel_out   = mmio_hit && (i_ldst_addr[3:2] == 2'd0);
  assign sel_cnt   = mmio_hit && (i_ldst_addr[3:2] == 2'd1);
  assign mmio_word = sel_out ? mmio_reg : (sel_cnt ? cycle_cnt : '0);

  // Only a full-word store may update the output register.
  // The counter is read-only, so any store to it is flagged as an error.
  assign mmio_store_bad = i_ldst_wr && ((sel_out && !is_word) || sel_cnt);
  assign mmio_reg_we    = i_ldst_wr && !ls_illegal && sel_out && is_word;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mmio_reg  <= '0;
      cycle_cnt <= '0;
    end else begin
      cycle_cnt <= cycle_cnt + 1'b1;
      if (mmio_reg_we) begin
        mmio_reg <= i_ldst_wrdata;
      end
    end
  end

  assign o_mmio_out = mmio_reg;
`else
  logic unused_ls_bits;
  assign unused_ls_bits = ^i_ldst_addr[IW-1:AW+2];

  assign mmio_hit       = 1'b0;
  assign mmio_store_bad = 1'b0;
  assign mmio_word      = '0;
`endif

  // Select the source word, move the addressed lane down to bit 0, and
  // zero-extend it to the access size.
  always_comb begin
    src_word = mmio_hit ? mmio_word : mem[ls_idx];
    shifted  = src_word >> lane_shift;
    ld_data  = src_word;
    if (is_byte) begin
      ld_data = {{(IW-8){1'b0}}, shifted[7:0]};
    end else if (is_half) begin
      ld_data = {{(IW-16){1'b0}}, shifted[15:0]};
    end
  end

  // Byte-enabled RAM write; bytes outside the mask are left unchanged.
  always_ff @(posedge clk) begin
    if (ram_we) begin
      for (int b = 0; b < 4; b++) begin
        if (wr_mask[b]) begin
          mem[ls_idx][b*8 +: 8] <= wr_data[b*8 +: 8];
        end
      end
    end
  end

  // Registered read side. Both ports sample the RAM at the same edge as
  // the write, so a colliding fetch sees the pre-write word. Reset drops
  // any request that is in flight.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      o_pc_rddata   <= '0;
      o_pc_valid    <= 1'b0;
      o_ldst_rddata <= '0;
      o_ldst_valid  <= 1'b0;
      o_err         <= 1'b0;
    end else begin
      o_pc_valid   <= i_pc_rd;
      o_ldst_valid <= i_ldst_rd;
      if (i_pc_rd) begin
        o_pc_rddata <= mem[pc_idx];
      end
      if (i_ldst_rd) begin
        o_ldst_rddata <= ls_illegal ? '0 : ld_data;
      end
      if (pc_bad || ls_bad) begin
        o_err <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_cpu_mem_responder.sv
// tb_cpu_mem_responder
// Self-checking bench for cpu_mem_responder. It uses a small RAM so that
// every word can be pre-filled. Expected values come from a byte-array
// model of memory, or are constants taken from the directed scenarios.
// Define RESP_MMIO_EN to also cover the MMIO register and counter.
module tb_cpu_mem_responder;

  localparam int DEPTH = 256;
  localparam int MEMB  = DEPTH * 4;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [31:0] i_pc_addr = '0;
  logic        i_pc_rd = 1'b0;
  logic [3:0]  i_pc_byte_en = 4'hF;
  logic [31:0] o_pc_rddata;
  logic        o_pc_valid;
  logic [31:0] i_ldst_addr = '0;
  logic        i_ldst_rd = 1'b0;
  logic        i_ldst_wr = 1'b0;
  logic [31:0] i_ldst_wrdata = '0;
  logic [3:0]  i_ldst_byte_en = 4'hF;
  logic [31:0] o_ldst_rddata;
  logic        o_ldst_valid;
  logic        o_err;
`ifdef RESP_MMIO_EN
  logic [31:0] o_mmio_out;
`endif

  int total = 0;
  int bad = 0;

  logic [7:0] model_mem [MEMB];

  cpu_mem_responder #(.IW(32), .DEPTH_WORDS(DEPTH)) dut (
    .clk(clk),
    .reset_n(reset_n),
    .i_pc_addr(i_pc_addr),
    .i_pc_rd(i_pc_rd),
    .i_pc_byte_en(i_pc_byte_en),
    .o_pc_rddata(o_pc_rddata),
    .o_pc_valid(o_pc_valid),
    .i_ldst_addr(i_ldst_addr),
    .i_ldst_rd(i_ldst_rd),
    .i_ldst_wr(i_ldst_wr),
    .i_ldst_wrdata(i_ldst_wrdata),
    .i_ldst_byte_en(i_ldst_byte_en),
    .o_ldst_rddata(o_ldst_rddata),
    .o_ldst_valid(o_ldst_valid),
`ifdef RESP_MMIO_EN
    .o_mmio_out(o_mmio_out),
`endif
    .o_err(o_err)
  );

  always #5 clk = ~clk;

  // Hard stop in case the sequence ever stalls.
  initial begin
    #2000000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic int nbytesOf(input logic [3:0] be);
    if (be == 4'b0001) return 1;
    if (be == 4'b0011) return 2;
    return 4;
  endfunction

  // Model read: gather nbytes consecutive bytes, little-endian, from the
  // aliased byte address.
  function automatic logic [31:0] modelLoad(input logic [31:0] addr, input logic [3:0] be);
    logic [31:0] v;
    int base;
    v = '0;
    base = int'(addr % MEMB);
    for (int i = 0; i < nbytesOf(be); i++) v[8*i +: 8] = model_mem[base + i];
    return v;
  endfunction

  task automatic modelStore(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] be);
    int base;
    base = int'(addr % MEMB);
    for (int i = 0; i < nbytesOf(be); i++) model_mem[base + i] = data[8*i +: 8];
  endtask

  // Present one cycle of requests, let the edge pass, then return the
  // request strobes to idle. Outputs can be sampled right after this returns.
  task automatic applyStimulus(input logic pc_rd, input logic [31:0] pc_addr, input logic [3:0] pc_be,
                               input logic rd, input logic wr, input logic [31:0] addr,
                               input logic [31:0] wdata, input logic [3:0] be);
    i_pc_rd        = pc_rd;
    i_pc_addr      = pc_addr;
    i_pc_byte_en   = pc_be;
    i_ldst_rd      = rd;
    i_ldst_wr      = wr;
    i_ldst_addr    = addr;
    i_ldst_wrdata  = wdata;
    i_ldst_byte_en = be;
    @(posedge clk);
    #1;
    i_pc_rd   = 1'b0;
    i_ldst_rd = 1'b0;
    i_ldst_wr = 1'b0;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    total++;
    assert (observed === expected) else begin
      bad++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  task automatic idle();
    applyStimulus(1'b0, 32'h0, 4'hF, 1'b0, 1'b0, 32'h0, 32'h0, 4'hF);
  endtask

  task automatic store(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] be);
    applyStimulus(1'b0, 32'h0, 4'hF, 1'b0, 1'b1, addr, data, be);
  endtask

  task automatic load(input logic [31:0] addr, input logic [3:0] be);
    applyStimulus(1'b0, 32'h0, 4'hF, 1'b1, 1'b0, addr, 32'h0, be);
  endtask

  task automatic resetPulse();
    #2 reset_n = 1'b0;
    #2 reset_n = 1'b1;
  endtask

  initial begin
    logic [31:0] addr;
    logic [31:0] pcaddr;
    logic [31:0] data;
    logic [31:0] exp_ld;
    logic [31:0] exp_pc;
    logic [3:0]  be;
    int          kind;
    int          sz;
    int          lane;

    // Reset state.
    #12;
    checkOutput("rst_pc_rddata", o_pc_rddata, 32'h0);
    checkOutput("rst_pc_valid", {31'b0, o_pc_valid}, 32'h0);
    checkOutput("rst_ld_rddata", o_ldst_rddata, 32'h0);
    checkOutput("rst_ld_valid", {31'b0, o_ldst_valid}, 32'h0);
    checkOutput("rst_err", {31'b0, o_err}, 32'h0);
    #1 reset_n = 1'b1;

    // Pre-fill every word so that all later reads are defined.
    for (int w = 0; w < DEPTH; w++) begin
      data = $urandom;
      addr = 32'(w) << 2;
      modelStore(addr, data, 4'hF);
      store(addr, data, 4'hF);
    end

    // Random legal traffic, with aliased addresses and dual-port reads.
    for (int n = 0; n < 300; n++) begin
      kind = int'($urandom_range(0, 2));
      sz   = int'($urandom_range(0, 2));
      be   = (sz == 0) ? 4'b0001 : (sz == 1) ? 4'b0011 : 4'b1111;
      lane = (sz == 0) ? int'($urandom_range(0, 3)) : (sz == 1) ? 2 * int'($urandom_range(0, 1)) : 0;
      addr = (32'($urandom_range(0, 63)) << 10) | (32'($urandom_range(0, DEPTH - 1)) << 2) | 32'(lane);
      if (kind == 0) begin
        data = $urandom;
        modelStore(addr, data, be);
        store(addr, data, be);
        checkOutput("rnd_store_novalid", {31'b0, o_ldst_valid}, 32'h0);
      end else begin
        pcaddr = 32'($urandom_range(0, DEPTH - 1)) << 2;
        exp_ld = modelLoad(addr, be);
        exp_pc = modelLoad(pcaddr, 4'hF);
        applyStimulus(kind == 2, pcaddr, 4'hF, 1'b1, 1'b0, addr, 32'h0, be);
        checkOutput("rnd_load_data", o_ldst_rddata, exp_ld);
        checkOutput("rnd_load_valid", {31'b0, o_ldst_valid}, 32'h1);
        if (kind == 2) checkOutput("rnd_pc_data", o_pc_rddata, exp_pc);
        checkOutput("rnd_pc_valid", {31'b0, o_pc_valid}, (kind == 2) ? 32'h1 : 32'h0);
      end
    end
    checkOutput("rnd_no_err", {31'b0, o_err}, 32'h0);

    // Word store, then load, then confirm valid is a single-cycle pulse.
    store(32'h100, 32'hDEADBEEF, 4'hF);
    modelStore(32'h100, 32'hDEADBEEF, 4'hF);
    load(32'h100, 4'hF);
    checkOutput("word_load", o_ldst_rddata, 32'hDEADBEEF);
    checkOutput("word_valid", {31'b0, o_ldst_valid}, 32'h1);
    idle();
    checkOutput("valid_pulse", {31'b0, o_ldst_valid}, 32'h0);
    checkOutput("rddata_hold", o_ldst_rddata, 32'hDEADBEEF);

    // Lane steering.
    store(32'h102, 32'h000000AA, 4'b0001);
    modelStore(32'h102, 32'h000000AA, 4'b0001);
    load(32'h100, 4'hF);
    checkOutput("byte_store_word", o_ldst_rddata, 32'hDEAABEEF);
    load(32'h102, 4'b0011);
    checkOutput("half_load_hi", o_ldst_rddata, 32'h0000DEAA);
    load(32'h103, 4'b0001);
    checkOutput("byte_load_3", o_ldst_rddata, 32'h000000DE);
    store(32'h106, 32'h0000CAFE, 4'b0011);
    modelStore(32'h106, 32'h0000CAFE, 4'b0011);
    load(32'h104, 4'hF);
    checkOutput("half_store_word", o_ldst_rddata, modelLoad(32'h104, 4'hF));
    load(32'h100 + 32'(MEMB * 5), 4'hF);
    checkOutput("alias_load", o_ldst_rddata, 32'hDEAABEEF);

    // Same-cycle collisions.
    store(32'h200, 32'h11111111, 4'hF);
    applyStimulus(1'b1, 32'h200, 4'hF, 1'b0, 1'b1, 32'h200, 32'h22222222, 4'hF);
    modelStore(32'h200, 32'h22222222, 4'hF);
    checkOutput("collide_old", o_pc_rddata, 32'h11111111);
    applyStimulus(1'b1, 32'h200, 4'hF, 1'b0, 1'b0, 32'h0, 32'h0, 4'hF);
    checkOutput("collide_new", o_pc_rddata, 32'h22222222);
    applyStimulus(1'b1, 32'h200, 4'hF, 1'b1, 1'b0, 32'h200, 32'h0, 4'hF);
    checkOutput("dual_read_pc", o_pc_rddata, 32'h22222222);
    checkOutput("dual_read_ld", o_ldst_rddata, 32'h22222222);

    // Reset while a load is being presented.
    i_ldst_addr    = 32'h100;
    i_ldst_byte_en = 4'hF;
    i_ldst_rd      = 1'b1;
    #3 reset_n = 1'b0;
    @(posedge clk);
    #1;
    checkOutput("midrst_valid", {31'b0, o_ldst_valid}, 32'h0);
    checkOutput("midrst_data", o_ldst_rddata, 32'h0);
    i_ldst_rd = 1'b0;
    #2 reset_n = 1'b1;
    @(posedge clk);
    #1;
    checkOutput("postrst_valid", {31'b0, o_ldst_valid}, 32'h0);
    checkOutput("postrst_data", o_ldst_rddata, 32'h0);
    checkOutput("postrst_pc", o_pc_rddata, 32'h0);
    load(32'h100, 4'hF);
    checkOutput("ram_retained", o_ldst_rddata, 32'hDEAABEEF);
    checkOutput("err_clear", {31'b0, o_err}, 32'h0);

`ifdef RESP_MMIO_EN
    // MMIO output register and cycle counter.
    store(32'hFFFF_FFF0, 32'h0000005A, 4'hF);
    checkOutput("mmio_out", o_mmio_out, 32'h5A);
    checkOutput("mmio_no_err", {31'b0, o_err}, 32'h0);
    load(32'hFFFF_FFF0, 4'hF);
    checkOutput("mmio_readback", o_ldst_rddata, 32'h5A);
    load(32'hFFFF_FFF4, 4'hF);
    data = o_ldst_rddata;
    idle();
    idle();
    load(32'hFFFF_FFF4, 4'hF);
    checkOutput("mmio_cnt_delta", o_ldst_rddata - data, 32'd3);
    load(32'h100, 4'hF);
    checkOutput("mmio_ram_intact", o_ldst_rddata, 32'hDEAABEEF);
    store(32'hFFFF_FFF0, 32'h000000FF, 4'b0001);
    checkOutput("mmio_sub_err", {31'b0, o_err}, 32'h1);
    checkOutput("mmio_sub_nowr", o_mmio_out, 32'h5A);
    resetPulse();
`endif

    // Misaligned and illegal load/store requests.
    load(32'h101, 4'b0011);
    checkOutput("mis_half_data", o_ldst_rddata, 32'h0);
    checkOutput("mis_half_valid", {31'b0, o_ldst_valid}, 32'h1);
    checkOutput("mis_half_err", {31'b0, o_err}, 32'h1);
    store(32'h106, 32'hDDDDDDDD, 4'hF);
    load(32'h104, 4'hF);
    checkOutput("mis_word_nowr", o_ldst_rddata, modelLoad(32'h104, 4'hF));
    checkOutput("err_sticky", {31'b0, o_err}, 32'h1);
    applyStimulus(1'b0, 32'h0, 4'hF, 1'b1, 1'b1, 32'h104, 32'h12345678, 4'hF);
    checkOutput("rdwr_data", o_ldst_rddata, 32'h0);
    checkOutput("rdwr_valid", {31'b0, o_ldst_valid}, 32'h1);
    load(32'h104, 4'hF);
    checkOutput("rdwr_nowr", o_ldst_rddata, modelLoad(32'h104, 4'hF));

    // Illegal byte enables on the load/store port.
    resetPulse();
    checkOutput("rst_clears_err", {31'b0, o_err}, 32'h0);
    load(32'h100, 4'b0111);
    checkOutput("bad_be_data", o_ldst_rddata, 32'h0);
    checkOutput("bad_be_err", {31'b0, o_err}, 32'h1);

    // Instruction port: misaligned address, then illegal byte enables.
    resetPulse();
    applyStimulus(1'b1, 32'h102, 4'hF, 1'b0, 1'b0, 32'h0, 32'h0, 4'hF);
    checkOutput("pc_mis_data", o_pc_rddata, 32'hDEAABEEF);
    checkOutput("pc_mis_valid", {31'b0, o_pc_valid}, 32'h1);
    checkOutput("pc_mis_err", {31'b0, o_err}, 32'h1);
    resetPulse();
    applyStimulus(1'b1, 32'h100, 4'b0011, 1'b0, 1'b0, 32'h0, 32'h0, 4'hF);
    checkOutput("pc_be_err", {31'b0, o_err}, 32'h1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
